meta_parser: RTL and testbench
==============================

# meta_parser

Receive-side counterpart of the metadata sender. It consumes the SUMP metadata byte stream (query response) one byte at a time from a byte receiver and decodes each token. Numeric fields (sample memory, max sample rate, probe count, protocol version) are latched into registers. String tokens are forwarded as a character stream. The block is used for loopback self-test of the metadata path and by any master-side logic that needs the device capabilities.

## Interface
- METADATA_MAX, 64, maximum accepted stream length in bytes, terminator included.
- clock  in  1  system clock; all logic on rising edge.
- extReset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse: clear all fields and arm the parser.
- byte_valid  in  1  single-cycle strobe: byte_in is valid this cycle.
- byte_in  in  8  received metadata byte.
- mem_size  out  32  value of key 0x21, big-endian assembled.
- max_rate  out  32  value of key 0x23.
- num_probes  out  8  value of key 0x40.
- proto_ver  out  8  value of key 0x41.
- str_valid  out  1  strobe: str_char is valid.
- str_key  out  8  key byte of the string currently being emitted (0x01–0x1F).
- str_char  out  8  string character; 0x00 marks end of string.
- busy  out  1  parser armed and not yet terminated.
- done  out  1  single-cycle pulse on a clean end-of-data token.
- error  out  1  sticky until next start or reset.

## Operation
- Token classes are set by byte[7:5] of the key byte. 0x00 is the end-of-data token. Keys 0x01–0x1F are null-terminated strings. Keys 0x20–0x3F carry a 32-bit MSB-first payload of 4 bytes. Keys 0x40–0x5F carry an 8-bit payload of 1 byte. Keys 0x60–0xFF are illegal.
- States:
  - IDLE: bytes ignored. start goes to KEY.
  - KEY:
    - 0x00 goes to DONE.
    - A string key latches str_key and goes to STRING.
    - A long key clears the shift register and count and goes to LONG.
    - A short key goes to SHORT.
    - An illegal key goes to ERROR.
  - STRING: every byte is emitted as str_char with str_valid. A 0x00 byte is emitted, then the parser returns to KEY.
  - LONG: shift_reg = {shift_reg[23:0], byte_in}. On the 4th byte the addressed register is committed (0x21 to mem_size, 0x23 to max_rate, other keys discarded), then the parser returns to KEY.
  - SHORT: the byte is committed (0x40 to num_probes, 0x41 to proto_ver, others discarded), then the parser returns to KEY.
  - DONE and ERROR: bytes ignored until start.
- Byte counter (7 bits) increments on every accepted byte while busy. Accepting byte number METADATA_MAX+1 goes to ERROR. A 0x00 terminator at exactly byte METADATA_MAX is legal.
- start clears mem_size, max_rate, num_probes, proto_ver, error and the byte counter. start is honoured in any state.
- start coincident with byte_valid: start wins and the byte is dropped.
- A truncated stream (start issued mid-token) abandons the partial field and leaves registers cleared. No partial commit ever occurs.
- A repeated key overwrites the earlier value (last wins).

## Timing
- Reset (extReset_n low, asynchronous): state IDLE. All outputs 0: mem_size, max_rate, num_probes, proto_ver, str_key, str_char, str_valid, busy, done, error.
- All outputs are registered.
- A field register updates on the clock edge that samples its final payload byte, so it is visible the cycle after that byte's byte_valid.
- str_valid/str_char appear 1 cycle after the corresponding byte_valid and last 1 cycle.
- done asserts 1 cycle after the 0x00 key's byte_valid and lasts 1 cycle. busy falls on the same edge.
- error rises 1 cycle after the offending byte_valid.
- busy rises 1 cycle after start.
- Back-to-back byte_valid on consecutive cycles must be accepted with no stall. There is no backpressure.

## Test plan
- Feed the full 47-byte standard stream (01 "Open Logic Sniffer v1.01" 00, 02 "3.08" 00, 21 00 00 40 00, 23 05 F5 E1 00, 40 20, 41 02, 00) at one byte per cycle:
  - mem_size=0x00004000, max_rate=0x05F5E100, num_probes=0x20, proto_ver=0x02.
  - 24+1 chars emitted with str_key=0x01, then 4+1 chars with str_key=0x02.
  - done pulses once, 1 cycle after byte 47. error=0.
- Same stream with 10 idle cycles between bytes: identical results. done occurs 1 cycle after the last byte.
- Stream 21 12 34, then start: mem_size stays 0. Then a fresh stream 21 12 34 56 78 00 gives mem_size=0x12345678 and done.
- Stream 40 08, then 7F: num_probes=0x08, error=1 one cycle after 7F. Subsequent bytes are ignored and done never pulses.
- Length limit: 63 bytes of string payload plus a 0x00 at byte 64 gives done. With 64 payload bytes, byte 65 sets error.
- Assert extReset_n low mid-LONG: all outputs read 0 asynchronously, state is IDLE, and bytes are ignored until start.

Source files
------------

// File: rtl/meta_parser.sv
// meta_parser
// Decodes a SUMP metadata byte stream, one byte per byte_valid strobe.
// Numeric tokens are latched into field registers. String tokens are
// forwarded one character per cycle.
//
// Ports:
//   clock, extReset_n   system clock, asynchronous active-low reset
//   start               clear all fields and arm the parser (wins over byte_valid)
//   byte_valid, byte_in received metadata byte strobe and data
//   mem_size, max_rate  32-bit fields for keys 0x21 / 0x23
//   num_probes          8-bit field for key 0x40
//   proto_ver           8-bit field for key 0x41
//   str_valid, str_key, str_char
//                       string character stream (0x00 char ends a string)
//   busy                parser armed and not yet terminated
//   done                one-cycle pulse on a clean end-of-data token
//   error               sticky until the next start or reset
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | not armed, bytes ignored
// KEY    | next byte is a token key
// STRING | forwarding string characters until a 0x00 byte
// LONG   | collecting a 4-byte MSB-first payload
// SHORT  | collecting a 1-byte payload
// DONE   | clean end of data, bytes ignored until start
// ERROR  | illegal key or stream too long, bytes ignored until start
module meta_parser #(
  parameter int METADATA_MAX = 64
) (
  input  logic        clock,
  input  logic        extReset_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] mem_size,
  output logic [31:0] max_rate,
  output logic [7:0]  num_probes,
  output logic [7:0]  proto_ver,
  output logic        str_valid,
  output logic [7:0]  str_key,
  output logic [7:0]  str_char,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY,
    ST_STRING,
    ST_LONG,
    ST_SHORT,
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t      state, state_nxt;

  logic [6:0]  byte_cnt, byte_cnt_nxt;
  logic [1:0]  long_cnt, long_cnt_nxt;
  logic [23:0] shift_reg, shift_reg_nxt;
  logic [7:0]  cur_key, cur_key_nxt;

  logic [31:0] mem_size_nxt, max_rate_nxt;
  logic [7:0]  num_probes_nxt, proto_ver_nxt;
  logic [7:0]  str_key_nxt, str_char_nxt;
  logic        str_valid_nxt, busy_nxt, done_nxt, error_nxt;

  logic        armed;
  logic        at_limit;
  logic [31:0] long_word;

  assign armed     = (state == ST_KEY) || (state == ST_STRING) ||
                     (state == ST_LONG) || (state == ST_SHORT);
  // METADATA_MAX bytes already accepted: any further byte overflows.
  assign at_limit  = (byte_cnt == 7'(METADATA_MAX));
  assign long_word = {shift_reg, byte_in};

  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    byte_cnt_nxt   = byte_cnt;
    long_cnt_nxt   = long_cnt;
    shift_reg_nxt  = shift_reg;
    cur_key_nxt    = cur_key;
    mem_size_nxt   = mem_size;
    max_rate_nxt   = max_rate;
    num_probes_nxt = num_probes;
    proto_ver_nxt  = proto_ver;
    str_key_nxt    = str_key;
    str_char_nxt   = str_char;
    str_valid_nxt  = 1'b0;
    done_nxt       = 1'b0;
    error_nxt      = error;

    if (start) begin
      // Any byte presented in the same cycle is dropped.
      state_nxt      = ST_KEY;
      byte_cnt_nxt   = '0;
      long_cnt_nxt   = '0;
      shift_reg_nxt  = '0;
      mem_size_nxt   = '0;
      max_rate_nxt   = '0;
      num_probes_nxt = '0;
      proto_ver_nxt  = '0;
      error_nxt      = 1'b0;
    end else if (byte_valid && armed) begin
      if (at_limit) begin
        state_nxt = ST_ERROR;
        error_nxt = 1'b1;
      end else begin
        byte_cnt_nxt = byte_cnt + 7'd1;
        case (state)
          ST_KEY: begin
            cur_key_nxt = byte_in;
            if (byte_in == 8'h00) begin
              state_nxt = ST_DONE;
              done_nxt  = 1'b1;
            end else begin
              case (byte_in[7:5])
                3'b000: begin
                  str_key_nxt = byte_in;
                  state_nxt   = ST_STRING;
                end
                3'b001: begin
                  shift_reg_nxt = '0;
                  long_cnt_nxt  = '0;
                  state_nxt     = ST_LONG;
                end
                3'b010: begin
                  state_nxt = ST_SHORT;
                end
                default: begin
                  state_nxt = ST_ERROR;
                  error_nxt = 1'b1;
                end
              endcase
            end
          end
          ST_STRING: begin
            str_valid_nxt = 1'b1;
            str_char_nxt  = byte_in;
            if (byte_in == 8'h00) begin
              state_nxt = ST_KEY;
            end
          end
          ST_LONG: begin
            if (long_cnt == 2'd3) begin
              // Commit only on the final byte so a truncated field never lands.
              case (cur_key)
                8'h21:   mem_size_nxt = long_word;
                8'h23:   max_rate_nxt = long_word;
                default: ;
              endcase
              state_nxt = ST_KEY;
            end else begin
              shift_reg_nxt = long_word[23:0];
              long_cnt_nxt  = long_cnt + 2'd1;
            end
          end
          ST_SHORT: begin
            case (cur_key)
              8'h40:   num_probes_nxt = byte_in;
              8'h41:   proto_ver_nxt  = byte_in;
              default: ;
            endcase
            state_nxt = ST_KEY;
          end
          default: ;
        endcase
      end
    end

    busy_nxt = (state_nxt == ST_KEY) || (state_nxt == ST_STRING) ||
               (state_nxt == ST_LONG) || (state_nxt == ST_SHORT);
  end

  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) begin
      byte_cnt   <= '0;
      long_cnt   <= '0;
      shift_reg  <= '0;
      cur_key    <= '0;
      mem_size   <= '0;
      max_rate   <= '0;
      num_probes <= '0;
      proto_ver  <= '0;
      str_key    <= '0;
      str_char   <= '0;
      str_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      byte_cnt   <= byte_cnt_nxt;
      long_cnt   <= long_cnt_nxt;
      shift_reg  <= shift_reg_nxt;
      cur_key    <= cur_key_nxt;
      mem_size   <= mem_size_nxt;
      max_rate   <= max_rate_nxt;
      num_probes <= num_probes_nxt;
      proto_ver  <= proto_ver_nxt;
      str_key    <= str_key_nxt;
      str_char   <= str_char_nxt;
      str_valid  <= str_valid_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      error      <= error_nxt;
    end
  end

endmodule

// File: tb/tb_meta_parser.sv
// Bench for meta_parser: directed streams plus random token streams,
// checked against a byte-walking reference model of the metadata format.
module tb_meta_parser;
  localparam int MAX = 64;

  logic        clock = 1'b0;
  logic        extReset_n = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic [31:0] mem_size, max_rate;
  logic [7:0]  num_probes, proto_ver, str_key, str_char;
  logic        str_valid, busy, done, error;

  meta_parser #(.METADATA_MAX(MAX)) dut (
    .clock(clock), .extReset_n(extReset_n), .start(start),
    .byte_valid(byte_valid), .byte_in(byte_in),
    .mem_size(mem_size), .max_rate(max_rate),
    .num_probes(num_probes), .proto_ver(proto_ver),
    .str_valid(str_valid), .str_key(str_key), .str_char(str_char),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [7:0]  stim[$];
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  int          done_cnt = 0;
  int          lat_bad = 0;
  logic        prev_bv = 1'b0;
  logic        prev_err = 1'b0;
  logic [7:0]  prev_byte = 8'h00;

  logic [31:0] e_mem, e_rate;
  logic [7:0]  e_probes, e_ver;
  logic        e_err, e_done;

  // Outputs change just after posedge, inputs at posedge+1: negedge sees both stable.
  always @(negedge clock) begin
    if (str_valid) begin
      got_q.push_back({str_key, str_char});
      if (!prev_bv) lat_bad++;
    end
    if (done) begin
      done_cnt++;
      if (!(prev_bv && prev_byte == 8'h00)) lat_bad++;
    end
    if (error && !prev_err && !prev_bv) lat_bad++;
    prev_err  = error;
    prev_bv   = byte_valid;
    prev_byte = byte_in;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Walks the stream byte by byte following the token rules.
  task automatic model_run();
    int pos;
    int n;
    int need;
    bit stop;
    logic [7:0]  k;
    logic [31:0] v;
    pos = 0; n = stim.size(); stop = 0;
    e_mem = 0; e_rate = 0; e_probes = 0; e_ver = 0; e_err = 0; e_done = 0;
    exp_q.delete();
    while (!stop && pos < n) begin
      if (pos >= MAX) begin e_err = 1; break; end
      k = stim[pos]; pos++;
      if (k == 8'h00) begin
        e_done = 1; stop = 1;
      end else if (k < 8'h20) begin
        while (1) begin
          if (pos >= n) begin stop = 1; break; end
          if (pos >= MAX) begin e_err = 1; stop = 1; break; end
          exp_q.push_back({k, stim[pos]});
          pos++;
          if (stim[pos-1] == 8'h00) break;
        end
      end else if (k < 8'h60) begin
        need = (k < 8'h40) ? 4 : 1;
        v = 0;
        for (int j = 0; j < need; j++) begin
          if (pos >= n) begin stop = 1; break; end
          if (pos >= MAX) begin e_err = 1; stop = 1; break; end
          v = (v << 8) | 32'(stim[pos]);
          pos++;
        end
        if (!stop) begin
          if (k == 8'h21) e_mem = v;
          if (k == 8'h23) e_rate = v;
          if (k == 8'h40) e_probes = v[7:0];
          if (k == 8'h41) e_ver = v[7:0];
        end
      end else begin
        e_err = 1; stop = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic pulse_start();
    start = 1; byte_valid = 1; byte_in = 8'h00;   // coincident byte must be dropped
    tick();
    start = 0; byte_valid = 0;
    got_q.delete(); done_cnt = 0; lat_bad = 0;
  endtask

  task automatic feed(input int gap);
    for (int i = 0; i < stim.size(); i++) begin
      byte_valid = 1; byte_in = stim[i];
      tick();
      byte_valid = 0; byte_in = 8'h00;
      for (int g = 0; g < gap; g++) tick();
    end
    repeat (3) tick();
  endtask

  task automatic check_results(input string tag);
    int bad;
    model_run();
    chk({tag, ".mem_size"}, mem_size, e_mem);
    chk({tag, ".max_rate"}, max_rate, e_rate);
    chk({tag, ".num_probes"}, 32'(num_probes), 32'(e_probes));
    chk({tag, ".proto_ver"}, 32'(proto_ver), 32'(e_ver));
    chk({tag, ".error"}, 32'(error), 32'(e_err));
    chk({tag, ".done_cnt"}, done_cnt, e_done ? 1 : 0);
    chk({tag, ".busy"}, 32'(busy), 32'(!(e_done || e_err)));
    chk({tag, ".nchars"}, got_q.size(), exp_q.size());
    bad = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) bad++;
    chk({tag, ".char_mismatch"}, bad, 0);
    chk({tag, ".latency"}, lat_bad, 0);
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
  endtask

  task automatic build_standard();
    stim.delete();
    stim.push_back(8'h01); push_str("Open Logic Sniffer v1.01"); stim.push_back(8'h00);
    stim.push_back(8'h02); push_str("3.08"); stim.push_back(8'h00);
    stim.push_back(8'h21); stim.push_back(8'h00); stim.push_back(8'h00);
    stim.push_back(8'h40); stim.push_back(8'h00);
    stim.push_back(8'h23); stim.push_back(8'h05); stim.push_back(8'hF5);
    stim.push_back(8'hE1); stim.push_back(8'h00);
    stim.push_back(8'h40); stim.push_back(8'h20);
    stim.push_back(8'h41); stim.push_back(8'h02);
    stim.push_back(8'h00);
  endtask

  task automatic check_standard(input string tag);
    int n1, n2;
    n1 = 0; n2 = 0;
    foreach (got_q[i]) begin
      if (got_q[i][15:8] == 8'h01) n1++;
      if (got_q[i][15:8] == 8'h02) n2++;
    end
    chk({tag, ".std_mem"}, mem_size, 32'h0000_4000);
    chk({tag, ".std_rate"}, max_rate, 32'h05F5_E100);
    chk({tag, ".std_probes"}, 32'(num_probes), 32'h20);
    chk({tag, ".std_ver"}, 32'(proto_ver), 32'h02);
    chk({tag, ".std_key1_chars"}, n1, 25);
    chk({tag, ".std_key2_chars"}, n2, 5);
    chk({tag, ".std_done"}, done_cnt, 1);
  endtask

  task automatic build_random();
    int ntok, r, len;
    stim.delete();
    ntok = $urandom_range(1, 8);
    for (int t = 0; t < ntok; t++) begin
      r = $urandom_range(0, 9);
      if (r <= 3 || r == 9) begin
        stim.push_back(8'($urandom_range(1, 31)));
        len = (r == 9) ? $urandom_range(20, 40) : $urandom_range(0, 6);
        for (int i = 0; i < len; i++) stim.push_back(8'($urandom_range(1, 255)));
        stim.push_back(8'h00);
      end else if (r <= 5) begin
        if (r == 4) stim.push_back($urandom_range(0, 1) ? 8'h21 : 8'h23);
        else stim.push_back(8'($urandom_range(8'h20, 8'h3F)));
        for (int i = 0; i < 4; i++) stim.push_back(8'($urandom));
      end else if (r <= 7 || $urandom_range(0, 3) != 0) begin
        if (r == 6) stim.push_back($urandom_range(0, 1) ? 8'h40 : 8'h41);
        else stim.push_back(8'($urandom_range(8'h40, 8'h5F)));
        stim.push_back(8'($urandom));
      end else begin
        stim.push_back(8'($urandom_range(8'h60, 8'hFF)));
      end
    end
    if ($urandom_range(0, 4) != 0) stim.push_back(8'h00);
    else begin
      r = $urandom_range(0, 2);
      for (int i = 0; i < r && stim.size() > 1; i++) void'(stim.pop_back());
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst.mem_size", mem_size, 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.error", 32'(error), 0);
    chk("rst.str_valid", 32'(str_valid), 0);
    @(negedge clock);
    extReset_n = 1;
    tick();

    // Bytes before start are ignored
    stim.delete(); stim.push_back(8'h00); stim.push_back(8'h7F);
    done_cnt = 0; lat_bad = 0;
    feed(0);
    chk("idle.done_cnt", done_cnt, 0);
    chk("idle.error", 32'(error), 0);

    // Standard stream, back-to-back and with gaps
    build_standard();
    chk("std.length", stim.size(), 47);
    pulse_start();
    chk("std.busy_after_start", 32'(busy), 1);
    feed(0);
    check_results("std_gap0");
    check_standard("std_gap0");
    pulse_start();
    feed(10);
    check_results("std_gap10");
    check_standard("std_gap10");

    // Truncated long field, then a fresh stream
    stim = '{8'h21, 8'h12, 8'h34};
    pulse_start();
    feed(0);
    chk("trunc.no_partial", mem_size, 0);
    pulse_start();
    chk("trunc.after_start", mem_size, 0);
    chk("trunc.busy", 32'(busy), 1);
    stim = '{8'h21, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00};
    feed(0);
    check_results("fresh");
    chk("fresh.mem", mem_size, 32'h1234_5678);

    // Illegal key after a short field
    stim = '{8'h40, 8'h08, 8'h7F, 8'h00, 8'h41, 8'h05};
    pulse_start();
    feed(0);
    check_results("illegal");
    chk("illegal.probes", 32'(num_probes), 32'h08);
    chk("illegal.error", 32'(error), 1);

    // Length limit: terminator exactly at byte MAX, then one byte too many
    stim.delete(); stim.push_back(8'h01);
    for (int i = 0; i < 61; i++) stim.push_back(8'h41);
    stim.push_back(8'h00); stim.push_back(8'h00);
    pulse_start();
    feed(0);
    check_results("limit_ok");
    chk("limit_ok.done", done_cnt, 1);
    stim.delete(); stim.push_back(8'h01);
    for (int i = 0; i < 62; i++) stim.push_back(8'h42);
    stim.push_back(8'h00); stim.push_back(8'h00);
    pulse_start();
    feed(0);
    check_results("limit_over");
    chk("limit_over.error", 32'(error), 1);

    // Asynchronous reset in the middle of a long field
    stim = '{8'h05, 8'h78, 8'h00, 8'h40, 8'h20, 8'h21, 8'hAA, 8'hBB};
    pulse_start();
    feed(0);
    chk("prerst.probes", 32'(num_probes), 32'h20);
    @(posedge clock); #3;
    extReset_n = 0;
    #1;
    chk("arst.mem_size", mem_size, 0);
    chk("arst.max_rate", max_rate, 0);
    chk("arst.num_probes", 32'(num_probes), 0);
    chk("arst.proto_ver", 32'(proto_ver), 0);
    chk("arst.str_key", 32'(str_key), 0);
    chk("arst.str_char", 32'(str_char), 0);
    chk("arst.str_valid", 32'(str_valid), 0);
    chk("arst.busy", 32'(busy), 0);
    chk("arst.done", 32'(done), 0);
    chk("arst.error", 32'(error), 0);
    #2;
    extReset_n = 1;
    tick();
    stim = '{8'hCC, 8'h00, 8'h40, 8'h11};
    done_cnt = 0;
    feed(0);
    chk("postrst.done_cnt", done_cnt, 0);
    chk("postrst.busy", 32'(busy), 0);
    chk("postrst.probes", 32'(num_probes), 0);

    // Random token streams
    for (int s = 0; s < 40; s++) begin
      build_random();
      pulse_start();
      feed($urandom_range(0, 2));
      check_results($sformatf("rand%0d", s));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
